// File: rtl/trap_scheduler_pkg.sv
// Shared definitions for trap_scheduler: cause codes, FSM state encodings, source indices.
// No logic of its own; priority helpers are pure functions used by the top.
package trap_scheduler_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_IO    = 3'd1,
    CAUSE_IRQ   = 3'd2,
    CAUSE_TIMER = 3'd3,
    CAUSE_SOFT  = 3'd4
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  localparam int SRC_IO    = 0;
  localparam int SRC_IRQ   = 1;
  localparam int SRC_TIMER = 2;
  localparam int SRC_SOFT  = 3;
  localparam int N_SRC     = 4;

  // Fixed priority, lowest index wins: io > irq > timer > soft.
  function automatic logic [N_SRC-1:0] prio_grant(input logic [N_SRC-1:0] req);
    logic [N_SRC-1:0] g;
    g = '0;
    if (req[SRC_IO])         g[SRC_IO]    = 1'b1;
    else if (req[SRC_IRQ])   g[SRC_IRQ]   = 1'b1;
    else if (req[SRC_TIMER]) g[SRC_TIMER] = 1'b1;
    else if (req[SRC_SOFT])  g[SRC_SOFT]  = 1'b1;
    return g;
  endfunction

  function automatic cause_e grant_cause(input logic [N_SRC-1:0] grant);
    cause_e c;
    c = CAUSE_NONE;
    if (grant[SRC_IO])         c = CAUSE_IO;
    else if (grant[SRC_IRQ])   c = CAUSE_IRQ;
    else if (grant[SRC_TIMER]) c = CAUSE_TIMER;
    else if (grant[SRC_SOFT])  c = CAUSE_SOFT;
    return c;
  endfunction

endpackage

// File: rtl/trap_scheduler_if.sv
// Bundle of trap request inputs, Z80 cycle status and hypervisor-facing trap outputs.
// master drives requests/CPU status; slave is the scheduler.
interface trap_scheduler_if #(
  parameter int TIMER_W = 16
);
  logic               m1_n;
  logic               irq_sys_n;
  logic               io_trap_req;
  logic [7:0]         io_trap_port;
  logic [TIMER_W-1:0] timer_reload;
  logic               soft_trap_req;
  logic               new_isr;
  logic               last_isr_jmp;
  logic               virtual_enabled;

  logic               trap_state;
  logic               nmi_n;
  logic               capture_address;
  logic [2:0]         cause;
  logic [7:0]         cause_port;
  logic [3:0]         pending;

  modport master (
    output m1_n, irq_sys_n, io_trap_req, io_trap_port, timer_reload,
           soft_trap_req, new_isr, last_isr_jmp, virtual_enabled,
    input  trap_state, nmi_n, capture_address, cause, cause_port, pending
  );

  modport slave (
    input  m1_n, irq_sys_n, io_trap_req, io_trap_port, timer_reload,
           soft_trap_req, new_isr, last_isr_jmp, virtual_enabled,
    output trap_state, nmi_n, capture_address, cause, cause_port, pending
  );
endinterface

// File: rtl/trap_scheduler_m1_sync.sv
// m1_sync: 2-flop synchronizer with registered rise/fall pulses; a pin edge shows as a 1-clk pulse 3 clk later.
// No backpressure: pulses are single-cycle and must be consumed on the cycle they appear.
module m1_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s3   <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= ~r_s3 & r_s2;
      r_fall <= r_s3 & ~r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/trap_scheduler.sv
// trap_scheduler: sticky trap sources, fixed-priority arbitration and RUN/PEND/TRAP sequencing of Z80 /NMI; TRAP_SOFT_EN adds the soft source.
// Latency: pending bit -> nmi_n low 1 clk, trap entry/exit on synchronized M1 falls; no backpressure, requests stay pending until taken.
module trap_scheduler
  import trap_scheduler_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  trap_scheduler_if.slave bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [N_SRC-1:0]   r_pending;
  logic [N_SRC-1:0]   w_set;
  logic [N_SRC-1:0]   w_take;
  logic [N_SRC-1:0]   w_grant;
  logic [7:0]         r_io_port;
  logic [7:0]         r_cause_port;
  cause_e             r_cause;
  logic               r_capture;
  logic               w_cap_nxt;
  logic               r_trap_state;
  logic               r_nmi_n;
  logic               w_load_cause;
  logic               w_clr_cause;
  logic               w_m1_lvl;
  logic               w_m1_rise;
  logic               w_m1_fall;
  logic               w_irq_lvl;
  logic               w_irq_rise;
  logic               w_irq_fall;
  logic               r_irq_lvl;
  logic               r_irq_taken;
  logic [TIMER_W-1:0] r_tmr_cnt;
  logic               w_tmr_fire;
  logic               w_unused;

  m1_sync u_m1_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.m1_n),
    .o_level (w_m1_lvl),
    .o_rise  (w_m1_rise),
    .o_fall  (w_m1_fall)
  );

  m1_sync u_irq_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.irq_sys_n),
    .o_level (w_irq_lvl),
    .o_rise  (w_irq_rise),
    .o_fall  (w_irq_fall)
  );

`ifdef TRAP_SOFT_EN
  assign w_unused = &{1'b0, w_m1_lvl, w_irq_rise, w_irq_fall};
`else
  assign w_unused = &{1'b0, w_m1_lvl, w_irq_rise, w_irq_fall, bus.soft_trap_req};
`endif

  // IRQ level only moves on M1 rising edges; once taken it must be seen high before re-arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_lvl   <= 1'b1;
      r_irq_taken <= 1'b0;
    end else begin
      if (w_m1_rise) begin
        r_irq_lvl <= w_irq_lvl;
      end
      if (w_take[SRC_IRQ]) begin
        r_irq_taken <= 1'b1;
      end else if (r_irq_lvl) begin
        r_irq_taken <= 1'b0;
      end
    end
  end

  // Reset to a constant; a zero count picks up timer_reload on the first clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr_cnt <= '0;
    end else if (r_tmr_cnt <= TIMER_W'(1)) begin
      r_tmr_cnt <= bus.timer_reload;
    end else begin
      r_tmr_cnt <= r_tmr_cnt - TIMER_W'(1);
    end
  end

  assign w_tmr_fire = (r_tmr_cnt == TIMER_W'(1));

  always_comb begin
    w_set            = '0;
    w_set[SRC_IO]    = bus.io_trap_req;
    w_set[SRC_IRQ]   = ~r_irq_lvl & ~r_irq_taken & ~w_take[SRC_IRQ];
    w_set[SRC_TIMER] = w_tmr_fire;
`ifdef TRAP_SOFT_EN
    w_set[SRC_SOFT]  = bus.soft_trap_req;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_io_port <= '0;
    end else begin
      r_pending <= (r_pending & ~w_take) | w_set;
      // A repeat I/O request keeps the first port unless the bit is being consumed now.
      if (bus.io_trap_req && !(r_pending[SRC_IO] && !w_take[SRC_IO])) begin
        r_io_port <= bus.io_trap_port;
      end
    end
  end

  assign w_grant = prio_grant(r_pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_TRAP;
      r_trap_state <= 1'b1;
      r_nmi_n      <= 1'b1;
      r_capture    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_trap_state <= (w_state_nxt == ST_TRAP);
      r_nmi_n      <= (w_state_nxt != ST_PEND);
      r_capture    <= w_cap_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_take       = '0;
    w_load_cause = 1'b0;
    w_clr_cause  = 1'b0;
    w_cap_nxt    = r_capture & ~w_m1_fall;
    case (r_state)
      ST_RUN: begin
        if (!bus.virtual_enabled) begin
          if (w_m1_fall) begin
            w_state_nxt = ST_TRAP;
          end
        end else if (|r_pending) begin
          w_state_nxt  = ST_PEND;
          w_take       = w_grant;
          w_load_cause = 1'b1;
        end
      end
      ST_PEND: begin
        if (w_m1_fall && (!bus.virtual_enabled || bus.new_isr)) begin
          w_state_nxt = ST_TRAP;
          w_cap_nxt   = bus.virtual_enabled;
        end
      end
      ST_TRAP: begin
        if (w_m1_fall && bus.last_isr_jmp && bus.virtual_enabled) begin
          w_state_nxt = ST_RUN;
          w_clr_cause = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cause      <= CAUSE_NONE;
      r_cause_port <= '0;
    end else if (w_clr_cause) begin
      r_cause      <= CAUSE_NONE;
      r_cause_port <= '0;
    end else if (w_load_cause) begin
      r_cause      <= grant_cause(w_grant);
      r_cause_port <= w_grant[SRC_IO] ? r_io_port : 8'h00;
    end
  end

  assign bus.trap_state      = r_trap_state;
  assign bus.nmi_n           = r_nmi_n;
  assign bus.capture_address = r_capture;
  assign bus.cause           = r_cause;
  assign bus.cause_port      = r_cause_port;
  assign bus.pending         = r_pending;

endmodule

// File: tb/tb_trap_scheduler.sv
// Scoreboard bench for trap_scheduler: directed stimulus pushes expected trap entries, a monitor checks each NMI/entry event.
// M1 runs free with a 12-clk period; build with or without TRAP_SOFT_EN.
module tb_trap_scheduler;

  typedef struct packed {
    logic [2:0] cause;
    logic [7:0] port;
    logic       cap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic have_cur = 1'b0;
  logic prev_nmi = 1'b1;
  logic prev_ts = 1'b1;

  trap_scheduler_if #(.TIMER_W(16)) bus ();

  trap_scheduler #(.TIMER_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.m1_n = 1'b1;
    #3;
    forever begin
      #40 bus.m1_n = 1'b0;
      #80 bus.m1_n = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic expect_trap(input logic [2:0] c, input logic [7:0] p, input logic cap);
    exp_t e;
    e.cause = c;
    e.port  = p;
    e.cap   = cap;
    exp_q.push_back(e);
  endtask

  task automatic pulse_io(input logic [7:0] p);
    bus.io_trap_port = p;
    bus.io_trap_req  = 1'b1;
    @(negedge clk);
    bus.io_trap_req  = 1'b0;
  endtask

  task automatic do_exit(input string tag);
    for (int i = 0; i < 300 && !bus.trap_state; i++) @(negedge clk);
    check({tag, "_entered"}, int'(bus.trap_state), 1);
    bus.last_isr_jmp = 1'b1;
    for (int i = 0; i < 100 && bus.trap_state; i++) @(negedge clk);
    check({tag, "_exited"}, int'(bus.trap_state), 0);
    bus.last_isr_jmp = 1'b0;
  endtask

  // Monitor: every NMI assertion must match the next expected trap; trap entry checks the capture strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_nmi = 1'b1;
        prev_ts  = 1'b1;
        have_cur = 1'b0;
      end else begin
        if (prev_nmi && !bus.nmi_n) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_trap: cause %0d port %0h, none expected", bus.cause, bus.cause_port);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            check("trap_cause", int'(bus.cause), int'(cur.cause));
            check("trap_port", int'(bus.cause_port), int'(cur.port));
          end
        end
        if (!prev_ts && bus.trap_state && have_cur) begin
          check("entry_capture", int'(bus.capture_address), int'(cur.cap));
          check("entry_cause", int'(bus.cause), int'(cur.cause));
          have_cur = 1'b0;
        end
        prev_nmi = bus.nmi_n;
        prev_ts  = bus.trap_state;
      end
    end
  end

  initial begin
    int t0;
    int t1;
    int cap_len;
    rst_n               = 1'b0;
    bus.irq_sys_n       = 1'b1;
    bus.io_trap_req     = 1'b0;
    bus.io_trap_port    = 8'h00;
    bus.timer_reload    = 16'd0;
    bus.soft_trap_req   = 1'b0;
    bus.new_isr         = 1'b1;
    bus.last_isr_jmp    = 1'b0;
    bus.virtual_enabled = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_trap_state", int'(bus.trap_state), 1);
    check("rst_nmi_n", int'(bus.nmi_n), 1);
    check("rst_capture", int'(bus.capture_address), 0);
    check("rst_cause", int'(bus.cause), 0);
    check("rst_cause_port", int'(bus.cause_port), 0);
    check("rst_pending", int'(bus.pending), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Exit from the reset TRAP state
    do_exit("reset_exit");
    check("run_trap_state", int'(bus.trap_state), 0);
    check("run_cause", int'(bus.cause), 0);
    check("run_nmi_n", int'(bus.nmi_n), 1);

    // Single I/O trap
    expect_trap(3'd1, 8'hA0, 1'b1);
    pulse_io(8'hA0);
    check("io_pending_set", int'(bus.pending), 1);
    check("io_nmi_not_yet", int'(bus.nmi_n), 1);
    @(negedge clk);
    check("io_nmi_next_clk", int'(bus.nmi_n), 0);
    check("io_pending_taken", int'(bus.pending), 0);
    for (int i = 0; i < 40 && !bus.capture_address; i++) @(negedge clk);
    check("io_capture_set", int'(bus.capture_address), 1);
    cap_len = 0;
    while (bus.capture_address && cap_len < 100) begin
      @(negedge clk);
      cap_len++;
    end
    check("io_capture_len", cap_len, 12);
    do_exit("io");
    check("io_exit_cause", int'(bus.cause), 0);
    check("io_exit_port", int'(bus.cause_port), 0);

    // Simultaneous IRQ and I/O: io first, irq afterwards without a new edge
    expect_trap(3'd1, 8'h40, 1'b1);
    expect_trap(3'd2, 8'h00, 1'b1);
    bus.irq_sys_n = 1'b0;
    pulse_io(8'h40);
    do_exit("simul_io");
    do_exit("simul_irq");
    repeat (60) @(negedge clk);
    check("irq_held_no_retrap", int'(bus.trap_state), 0);
    check("irq_held_pending", int'(bus.pending), 0);
    bus.irq_sys_n = 1'b1;
    repeat (30) @(negedge clk);
    expect_trap(3'd2, 8'h00, 1'b1);
    bus.irq_sys_n = 1'b0;
    do_exit("irq_reassert");
    bus.irq_sys_n = 1'b1;
    repeat (30) @(negedge clk);

    // Timer: period 5, then disabled
    expect_trap(3'd3, 8'h00, 1'b1);
    expect_trap(3'd3, 8'h00, 1'b1);
    bus.timer_reload = 16'd5;
    for (int i = 0; i < 40 && !bus.pending[2]; i++) @(negedge clk);
    check("timer_first_fire", int'(bus.pending[2]), 1);
    t0 = cyc;
    for (int i = 0; i < 10 && bus.pending[2]; i++) @(negedge clk);
    for (int i = 0; i < 20 && !bus.pending[2]; i++) @(negedge clk);
    t1 = cyc;
    bus.timer_reload = 16'd0;
    check("timer_period", t1 - t0, 5);
    do_exit("timer1");
    do_exit("timer2");
    repeat (40) @(negedge clk);
    check("timer_zero_idle", int'(bus.pending), 0);
    check("timer_zero_run", int'(bus.trap_state), 0);

    // Virtualization dropped in PEND
    bus.new_isr = 1'b0;
    expect_trap(3'd1, 8'h11, 1'b0);
    pulse_io(8'h11);
    for (int i = 0; i < 10 && bus.nmi_n; i++) @(negedge clk);
    check("virt_off_pend", int'(bus.nmi_n), 0);
    bus.virtual_enabled = 1'b0;
    for (int i = 0; i < 40 && !bus.trap_state; i++) @(negedge clk);
    check("virt_off_trap", int'(bus.trap_state), 1);
    check("virt_off_cause_kept", int'(bus.cause), 1);
    check("virt_off_port_kept", int'(bus.cause_port), 8'h11);
    bus.last_isr_jmp = 1'b1;
    repeat (40) @(negedge clk);
    check("virt_off_no_exit", int'(bus.trap_state), 1);
    bus.virtual_enabled = 1'b1;
    bus.new_isr = 1'b1;
    for (int i = 0; i < 40 && bus.trap_state; i++) @(negedge clk);
    check("virt_on_exit", int'(bus.trap_state), 0);
    bus.last_isr_jmp = 1'b0;
    check("virt_on_exit_cause", int'(bus.cause), 0);

    // Reset while PEND with a request still pending
    expect_trap(3'd1, 8'h22, 1'b1);
    bus.io_trap_port = 8'h22;
    bus.io_trap_req  = 1'b1;
    @(negedge clk);
    bus.io_trap_port = 8'h33;
    @(negedge clk);
    bus.io_trap_req  = 1'b0;
    check("rstpend_nmi_low", int'(bus.nmi_n), 0);
    check("rstpend_repending", int'(bus.pending), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstpend_nmi_release", int'(bus.nmi_n), 1);
    check("rstpend_pending_lost", int'(bus.pending), 0);
    check("rstpend_trap_state", int'(bus.trap_state), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_exit("post_reset");
    repeat (20) @(negedge clk);
    check("post_reset_idle", int'(bus.pending), 0);

    // Soft source
`ifdef TRAP_SOFT_EN
    expect_trap(3'd4, 8'h00, 1'b1);
    bus.soft_trap_req = 1'b1;
    @(negedge clk);
    bus.soft_trap_req = 1'b0;
    check("soft_pending", int'(bus.pending), 8);
    do_exit("soft");
`else
    bus.soft_trap_req = 1'b1;
    @(negedge clk);
    bus.soft_trap_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pending != 4'd0 || !bus.nmi_n) break;
    end
    check("soft_off_pending", int'(bus.pending), 0);
    check("soft_off_nmi", int'(bus.nmi_n), 1);
`endif

    repeat (30) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
